regroup_table_cfg: RTL and testbench
====================================

REGROUP_TABLE_CFG -- requirements
Module: regroup_table_cfg

Interface
REQ-001 Parameter TABLE_DEPTH, default 256, number of regroup-table RAM entries (address width 8).
REQ-002 i_clk  input  1  single clock; all logic on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_cfg_wr  input  1  one-cycle command pulse: write/update entry.
REQ-005 iv_cfg_flowid  input  14  flow ID of entry; sampled with i_cfg_wr.
REQ-006 iv_cfg_dmac_outport  input  57  DMAC+outport payload; sampled with i_cfg_wr.
REQ-007 i_cfg_clear  input  1  one-cycle command pulse: clear whole table.
REQ-008 o_regroup_ram_rd / ov_regroup_ram_raddr  output  1/8  RAM read port, read data valid 2 cycles after rd.
REQ-009 iv_regroup_ram_rdata  input  71  RAM read data {flowid[70:57], dmac_outport[56:0]}.
REQ-010 o_regroup_ram_wr / ov_regroup_ram_waddr / ov_regroup_ram_wdata  output  1/8/71  RAM write port, one-cycle write strobe.
REQ-011 o_cfg_busy  output  1  command in progress; new commands ignored.
REQ-012 o_cfg_done  output  1  one-cycle pulse, command completed.
REQ-013 o_cfg_err  output  1  one-cycle pulse with o_cfg_done, command rejected.
REQ-014 ov_entry_num  output  9  count of valid entries, 0..256.

Function
REQ-015 Entries are kept packed at addresses 0..ov_entry_num-1, so a sequential searcher stopping at the first all-zero word sees every entry.
REQ-016 All outputs are registered; states IDLE_S, RD_S, WAIT_S, CMP_S, CLEAR_S.
REQ-017 IDLE_S: i_cfg_clear takes priority over i_cfg_wr when both are high; a command is accepted only in IDLE_S; o_cfg_busy goes high on the accept edge.
REQ-018 i_cfg_wr with {flowid,payload}==71'b0: rejected next edge (done=1, err=1); no RAM access; stay IDLE_S.
REQ-019 i_cfg_wr with ov_entry_num==0: on the accept edge wr=1, waddr=0, wdata={flowid,payload}, done=1, entry_num<=1; stay IDLE_S.
REQ-020 Otherwise: latch flowid/payload, index<=0, go RD_S.
REQ-021 RD_S: rd=1, raddr=index, go WAIT_S; WAIT_S: rd=0, go CMP_S; CMP_S: rdata valid; 3 cycles per entry.
REQ-022 CMP_S match (rdata[70:57]==latched flowid): wr=1 at waddr=index, wdata=new word, done=1, entry_num unchanged, go IDLE_S.
REQ-023 CMP_S miss, index<entry_num-1: index+1, go RD_S.
REQ-024 CMP_S miss, index==entry_num-1: if entry_num==256, done=1, err=1, no write; else wr=1 at waddr=entry_num[7:0], entry_num+1, done=1; go IDLE_S.
REQ-025 Clear: CLEAR_S writes 71'b0 to addresses 0..255, one per cycle (256 write strobes); after address 255, entry_num<=0, done=1, go IDLE_S.
REQ-026 o_regroup_ram_wr, o_cfg_done, o_cfg_err default 0 every cycle not specified above (pulses exactly one cycle).
REQ-027 o_cfg_busy is low whenever the state is IDLE_S; commands arriving while busy are dropped without effect.
REQ-028 Address counters do not wrap past 255; entry_num never exceeds 256.

Reset
REQ-029 While i_rst is high: state IDLE_S, all outputs 0, entry_num 0, latched registers 0; effect immediate (asynchronous).
REQ-030 Reset mid-search or mid-clear aborts the command with no done pulse; RAM contents are not restored, and software shall issue i_cfg_clear after reset.

Verification
REQ-031 Empty table, wr flowid=0x0005 payload=0x1 -> wr at addr 0, data {0x0005,0x1}, done, entry_num=1, busy never high.
REQ-032 Entries flowid 1,2,3 in addr 0..2; wr flowid=2 payload=0xAB -> reads addr 0,1, write addr 1 with 0xAB, entry_num=3, done 6 cycles after accept.
REQ-033 Same table; wr flowid=9 -> 3 reads, write addr 3, entry_num=4.
REQ-034 Table full (256 entries), wr new flowid -> 256 reads, done+err, no write, entry_num=256; wr of existing flowid updates in place.
REQ-035 clear and wr asserted in same cycle -> clear executes, 256 zero writes, entry_num=0, wr dropped; wr during clear ignored.
REQ-036 Assert i_rst during search at index 1 -> outputs 0 immediately, no done, IDLE_S after release.

Source files
------------

// File: rtl/regroup_table_cfg.sv
// Regroup-table configuration engine: inserts, updates and clears flow entries
// in an external RAM, keeping valid entries packed at addresses 0..entry_num-1.
module regroup_table_cfg #(
  parameter int unsigned TABLE_DEPTH = 256
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_cfg_wr,
  input  logic [13:0]                      iv_cfg_flowid,
  input  logic [56:0]                      iv_cfg_dmac_outport,
  input  logic                             i_cfg_clear,
  output logic                             o_regroup_ram_rd,
  output logic [$clog2(TABLE_DEPTH)-1:0]   ov_regroup_ram_raddr,
  input  logic [70:0]                      iv_regroup_ram_rdata,
  output logic                             o_regroup_ram_wr,
  output logic [$clog2(TABLE_DEPTH)-1:0]   ov_regroup_ram_waddr,
  output logic [70:0]                      ov_regroup_ram_wdata,
  output logic                             o_cfg_busy,
  output logic                             o_cfg_done,
  output logic                             o_cfg_err,
  output logic [$clog2(TABLE_DEPTH):0]     ov_entry_num
);

  localparam int unsigned AW = $clog2(TABLE_DEPTH);
  localparam int unsigned NW = AW + 1;
  localparam int unsigned FW = 14;
  localparam int unsigned PW = 57;
  localparam int unsigned DW = FW + PW;

  typedef enum logic [2:0] {
    IDLE_S,
    RD_S,
    WAIT_S,
    CMP_S,
    CLEAR_S
  } state_t;

  state_t          state_q, state_d;
  logic [FW-1:0]   flowid_q, flowid_d;
  logic [PW-1:0]   payload_q, payload_d;
  logic [AW-1:0]   index_q, index_d;
  logic [AW-1:0]   clr_addr_q, clr_addr_d;
  logic [NW-1:0]   entry_num_q, entry_num_d;
  logic            rd_q, rd_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            wr_q, wr_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [DW-1:0]   new_word;
  logic [DW-1:0]   held_word;
  logic [FW-1:0]   rd_flowid;
  logic            last_idx;
  logic            table_full;
  logic            last_clr;
  logic            rdata_unused;

  assign new_word   = {iv_cfg_flowid, iv_cfg_dmac_outport};
  assign held_word  = {flowid_q, payload_q};
  assign rd_flowid  = iv_regroup_ram_rdata[DW-1:PW];
  assign last_idx   = ({1'b0, index_q} == (entry_num_q - NW'(1)));
  assign table_full = (entry_num_q == NW'(TABLE_DEPTH));
  assign last_clr   = (clr_addr_q == AW'(TABLE_DEPTH - 1));
  // Only the flow ID field of a stored word takes part in matching.
  assign rdata_unused = ^iv_regroup_ram_rdata[PW-1:0];

  // State and datapath registers; every output is driven straight from a flop.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE_S;
      flowid_q    <= '0;
      payload_q   <= '0;
      index_q     <= '0;
      clr_addr_q  <= '0;
      entry_num_q <= '0;
      rd_q        <= 1'b0;
      raddr_q     <= '0;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flowid_q    <= flowid_d;
      payload_q   <= payload_d;
      index_q     <= index_d;
      clr_addr_q  <= clr_addr_d;
      entry_num_q <= entry_num_d;
      rd_q        <= rd_d;
      raddr_q     <= raddr_d;
      wr_q        <= wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // Next-state and next-output logic; read strobes are launched on entry to RD_S.
  always_comb begin
    state_d     = state_q;
    flowid_d    = flowid_q;
    payload_d   = payload_q;
    index_d     = index_q;
    clr_addr_d  = clr_addr_q;
    entry_num_d = entry_num_q;
    rd_d        = 1'b0;
    raddr_d     = raddr_q;
    wr_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE_S: begin
        if (i_cfg_clear) begin
          clr_addr_d = '0;
          state_d    = CLEAR_S;
        end else if (i_cfg_wr) begin
          if (new_word == '0) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (entry_num_q == '0) begin
            wr_d        = 1'b1;
            waddr_d     = '0;
            wdata_d     = new_word;
            done_d      = 1'b1;
            entry_num_d = NW'(1);
          end else begin
            flowid_d  = iv_cfg_flowid;
            payload_d = iv_cfg_dmac_outport;
            index_d   = '0;
            rd_d      = 1'b1;
            raddr_d   = '0;
            state_d   = RD_S;
          end
        end
      end

      RD_S: state_d = WAIT_S;

      WAIT_S: state_d = CMP_S;

      CMP_S: begin
        if (rd_flowid == flowid_q) begin
          wr_d    = 1'b1;
          waddr_d = index_q;
          wdata_d = held_word;
          done_d  = 1'b1;
          state_d = IDLE_S;
        end else if (!last_idx) begin
          index_d = index_q + AW'(1);
          rd_d    = 1'b1;
          raddr_d = index_q + AW'(1);
          state_d = RD_S;
        end else if (table_full) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE_S;
        end else begin
          // Append right behind the last valid entry to keep the table packed.
          wr_d        = 1'b1;
          waddr_d     = entry_num_q[AW-1:0];
          wdata_d     = held_word;
          entry_num_d = entry_num_q + NW'(1);
          done_d      = 1'b1;
          state_d     = IDLE_S;
        end
      end

      CLEAR_S: begin
        wr_d    = 1'b1;
        waddr_d = clr_addr_q;
        wdata_d = '0;
        if (last_clr) begin
          entry_num_d = '0;
          done_d      = 1'b1;
          state_d     = IDLE_S;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end

      default: state_d = IDLE_S;
    endcase

    busy_d = (state_d != IDLE_S);
  end

  assign o_regroup_ram_rd     = rd_q;
  assign ov_regroup_ram_raddr = raddr_q;
  assign o_regroup_ram_wr     = wr_q;
  assign ov_regroup_ram_waddr = waddr_q;
  assign ov_regroup_ram_wdata = wdata_q;
  assign o_cfg_busy           = busy_q;
  assign o_cfg_done           = done_q;
  assign o_cfg_err            = err_q;
  assign ov_entry_num         = entry_num_q;

endmodule

// File: tb/tb_regroup_table_cfg.sv
// Directed bench: a full-depth instance for normal traffic and a 4-entry
// instance so the table-full case stays short.
module tb_regroup_table_cfg;

  logic clk = 1'b0;
  logic rst;
  logic [13:0] flowid;
  logic [56:0] payload;

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        b_wr, b_clear, b_rd, b_wwr, b_busy, b_done, b_err;
  logic [7:0]  b_raddr, b_waddr;
  logic [70:0] b_rdata, b_wdata;
  logic [8:0]  b_num;

  logic        s_wr, s_clear, s_rd, s_wwr, s_busy, s_done, s_err;
  logic [1:0]  s_raddr, s_waddr;
  logic [70:0] s_rdata, s_wdata;
  logic [2:0]  s_num;

  regroup_table_cfg #(.TABLE_DEPTH(256)) u_big (
    .i_clk(clk), .i_rst(rst), .i_cfg_wr(b_wr), .iv_cfg_flowid(flowid),
    .iv_cfg_dmac_outport(payload), .i_cfg_clear(b_clear),
    .o_regroup_ram_rd(b_rd), .ov_regroup_ram_raddr(b_raddr),
    .iv_regroup_ram_rdata(b_rdata), .o_regroup_ram_wr(b_wwr),
    .ov_regroup_ram_waddr(b_waddr), .ov_regroup_ram_wdata(b_wdata),
    .o_cfg_busy(b_busy), .o_cfg_done(b_done), .o_cfg_err(b_err),
    .ov_entry_num(b_num)
  );

  regroup_table_cfg #(.TABLE_DEPTH(4)) u_small (
    .i_clk(clk), .i_rst(rst), .i_cfg_wr(s_wr), .iv_cfg_flowid(flowid),
    .iv_cfg_dmac_outport(payload), .i_cfg_clear(s_clear),
    .o_regroup_ram_rd(s_rd), .ov_regroup_ram_raddr(s_raddr),
    .iv_regroup_ram_rdata(s_rdata), .o_regroup_ram_wr(s_wwr),
    .ov_regroup_ram_waddr(s_waddr), .ov_regroup_ram_wdata(s_wdata),
    .o_cfg_busy(s_busy), .o_cfg_done(s_done), .o_cfg_err(s_err),
    .ov_entry_num(s_num)
  );

  // RAM models with two-cycle read latency, plus strobe monitors.
  logic [70:0] b_mem [256];
  logic [70:0] s_mem [4];
  logic [70:0] b_p1, s_p1;
  int b_wcnt = 0, b_zcnt = 0, b_rcnt = 0, b_dcnt = 0;
  int s_wcnt = 0, s_rcnt = 0;
  logic [7:0]  b_last_waddr, b_last_raddr;
  logic [70:0] b_last_wdata, s_last_wdata;
  logic [1:0]  s_last_waddr, s_last_raddr;

  always @(posedge clk) begin
    if (b_wwr) begin
      b_mem[b_waddr] <= b_wdata;
      b_wcnt <= b_wcnt + 1;
      if (b_wdata == 71'd0) b_zcnt <= b_zcnt + 1;
      b_last_waddr <= b_waddr;
      b_last_wdata <= b_wdata;
    end
    if (b_rd) begin
      b_p1 <= b_mem[b_raddr];
      b_rcnt <= b_rcnt + 1;
      b_last_raddr <= b_raddr;
    end
    b_rdata <= b_p1;
    if (b_done) b_dcnt <= b_dcnt + 1;
    if (s_wwr) begin
      s_mem[s_waddr] <= s_wdata;
      s_wcnt <= s_wcnt + 1;
      s_last_waddr <= s_waddr;
      s_last_wdata <= s_wdata;
    end
    if (s_rd) begin
      s_p1 <= s_mem[s_raddr];
      s_rcnt <= s_rcnt + 1;
      s_last_raddr <= s_raddr;
    end
    s_rdata <= s_p1;
  end

  // Issue one command and wait (bounded) for done; cyc counts edges after accept, -1 on timeout.
  task automatic run_cmd(input bit sm, input bit clr, input bit wr, input logic [13:0] f,
                         input logic [56:0] p, input int inject,
                         output int cyc, output logic err, output logic busy_seen);
    cyc = -1;
    err = 1'b0;
    busy_seen = 1'b0;
    @(negedge clk);
    flowid = f;
    payload = p;
    if (sm) begin s_clear = clr; s_wr = wr; end
    else begin b_clear = clr; b_wr = wr; end
    @(posedge clk);
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (k == 0) begin s_clear = 1'b0; s_wr = 1'b0; b_clear = 1'b0; b_wr = 1'b0; end
      if (k == inject) b_wr = 1'b1;
      if (k == inject + 1) b_wr = 1'b0;
      busy_seen = busy_seen | (sm ? s_busy : b_busy);
      if (sm ? s_done : b_done) begin
        cyc = k;
        err = sm ? s_err : b_err;
        break;
      end
      @(posedge clk);
    end
    b_wr = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  int cyc;
  logic err, busy_seen;
  int w0, z0, r0, d0;

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if ({b_rd, b_wwr, b_busy, b_done, b_err} !== 5'b0) begin errors++; $display("FAIL reset_strobes: got %b want 00000", {b_rd, b_wwr, b_busy, b_done, b_err}); end
    checks++; if (b_num !== 9'd0) begin errors++; $display("FAIL reset_entry_num: got %0d want 0", b_num); end
    checks++; if ({b_raddr, b_waddr} !== 16'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", {b_raddr, b_waddr}); end
    checks++; if (b_wdata !== 71'd0) begin errors++; $display("FAIL reset_wdata: got %h want 0", b_wdata); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clear();
    w0 = b_wcnt; z0 = b_zcnt;
    run_cmd(1'b0, 1'b1, 1'b0, 14'h0, 57'h0, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 256) begin errors++; $display("FAIL clear_latency: got %0d want 256", cyc); end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL clear_busy: got %b want 1", busy_seen); end
    checks++; if (b_wcnt - w0 !== 256) begin errors++; $display("FAIL clear_writes: got %0d want 256", b_wcnt - w0); end
    checks++; if (b_zcnt - z0 !== 256) begin errors++; $display("FAIL clear_zero_writes: got %0d want 256", b_zcnt - z0); end
    checks++; if (b_last_waddr !== 8'd255) begin errors++; $display("FAIL clear_last_addr: got %0d want 255", b_last_waddr); end
    checks++; if (b_num !== 9'd0) begin errors++; $display("FAIL clear_entry_num: got %0d want 0", b_num); end
    w0 = s_wcnt;
    run_cmd(1'b1, 1'b1, 1'b0, 14'h0, 57'h0, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL small_clear_latency: got %0d want 4", cyc); end
    checks++; if (s_wcnt - w0 !== 4) begin errors++; $display("FAIL small_clear_writes: got %0d want 4", s_wcnt - w0); end
  endtask

  task automatic test_first_write();
    w0 = b_wcnt; r0 = b_rcnt;
    run_cmd(1'b0, 1'b0, 1'b1, 14'h0005, 57'h1, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 0) begin errors++; $display("FAIL first_latency: got %0d want 0", cyc); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL first_busy: got %b want 0", busy_seen); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL first_err: got %b want 0", err); end
    checks++; if (b_wcnt - w0 !== 1 || b_rcnt - r0 !== 0) begin errors++; $display("FAIL first_strobes: got wr=%0d rd=%0d want wr=1 rd=0", b_wcnt - w0, b_rcnt - r0); end
    checks++; if (b_last_waddr !== 8'd0) begin errors++; $display("FAIL first_waddr: got %0d want 0", b_last_waddr); end
    checks++; if (b_last_wdata !== {14'h0005, 57'h1}) begin errors++; $display("FAIL first_wdata: got %h want %h", b_last_wdata, {14'h0005, 57'h1}); end
    checks++; if (b_num !== 9'd1) begin errors++; $display("FAIL first_entry_num: got %0d want 1", b_num); end
  endtask

  task automatic test_zero_reject();
    w0 = b_wcnt;
    run_cmd(1'b0, 1'b0, 1'b1, 14'h0, 57'h0, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 0) begin errors++; $display("FAIL zero_latency: got %0d want 0", cyc); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL zero_err: got %b want 1", err); end
    checks++; if (b_wcnt - w0 !== 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", b_wcnt - w0); end
    checks++; if (b_num !== 9'd1) begin errors++; $display("FAIL zero_entry_num: got %0d want 1", b_num); end
  endtask

  task automatic test_build();
    run_cmd(1'b0, 1'b1, 1'b0, 14'h0, 57'h0, -1, cyc, err, busy_seen);
    checks++; if (b_num !== 9'd0) begin errors++; $display("FAIL build_clear: got %0d want 0", b_num); end
    for (int i = 0; i < 3; i++) begin
      run_cmd(1'b0, 1'b0, 1'b1, 14'(i + 1), 57'(16 * (i + 1)), -1, cyc, err, busy_seen);
      checks++; if (cyc !== 3 * i || b_last_waddr !== 8'(i)) begin errors++; $display("FAIL build_entry%0d: got cyc=%0d addr=%0d want cyc=%0d addr=%0d", i, cyc, b_last_waddr, 3 * i, i); end
    end
    checks++; if (b_num !== 9'd3) begin errors++; $display("FAIL build_entry_num: got %0d want 3", b_num); end
  endtask

  task automatic test_update();
    r0 = b_rcnt; w0 = b_wcnt;
    run_cmd(1'b0, 1'b0, 1'b1, 14'h0002, 57'hAB, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL update_latency: got %0d want 6", cyc); end
    checks++; if (b_rcnt - r0 !== 2 || b_last_raddr !== 8'd1) begin errors++; $display("FAIL update_reads: got n=%0d last=%0d want n=2 last=1", b_rcnt - r0, b_last_raddr); end
    checks++; if (b_wcnt - w0 !== 1 || b_last_waddr !== 8'd1) begin errors++; $display("FAIL update_waddr: got n=%0d addr=%0d want n=1 addr=1", b_wcnt - w0, b_last_waddr); end
    checks++; if (b_mem[1] !== {14'h0002, 57'hAB}) begin errors++; $display("FAIL update_word: got %h want %h", b_mem[1], {14'h0002, 57'hAB}); end
    checks++; if (b_num !== 9'd3 || err !== 1'b0) begin errors++; $display("FAIL update_num_err: got num=%0d err=%b want 3/0", b_num, err); end
  endtask

  task automatic test_append();
    r0 = b_rcnt;
    run_cmd(1'b0, 1'b0, 1'b1, 14'h0009, 57'h99, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL append_latency: got %0d want 9", cyc); end
    checks++; if (b_rcnt - r0 !== 3 || b_last_raddr !== 8'd2) begin errors++; $display("FAIL append_reads: got n=%0d last=%0d want n=3 last=2", b_rcnt - r0, b_last_raddr); end
    checks++; if (b_last_waddr !== 8'd3 || b_mem[3] !== {14'h0009, 57'h99}) begin errors++; $display("FAIL append_write: got addr=%0d data=%h want addr=3", b_last_waddr, b_mem[3]); end
    checks++; if (b_num !== 9'd4) begin errors++; $display("FAIL append_entry_num: got %0d want 4", b_num); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      run_cmd(1'b1, 1'b0, 1'b1, 14'(8'h11 + i), 57'(i + 1), -1, cyc, err, busy_seen);
      checks++; if (cyc !== 3 * i || s_last_waddr !== 2'(i)) begin errors++; $display("FAIL full_fill%0d: got cyc=%0d addr=%0d want cyc=%0d addr=%0d", i, cyc, s_last_waddr, 3 * i, i); end
    end
    checks++; if (s_num !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", s_num); end
    r0 = s_rcnt; w0 = s_wcnt;
    run_cmd(1'b1, 1'b0, 1'b1, 14'h0020, 57'h66, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 12 || err !== 1'b1) begin errors++; $display("FAIL full_reject: got cyc=%0d err=%b want 12/1", cyc, err); end
    checks++; if (s_rcnt - r0 !== 4 || s_wcnt - w0 !== 0) begin errors++; $display("FAIL full_strobes: got rd=%0d wr=%0d want 4/0", s_rcnt - r0, s_wcnt - w0); end
    checks++; if (s_num !== 3'd4) begin errors++; $display("FAIL full_count_after: got %0d want 4", s_num); end
    run_cmd(1'b1, 1'b0, 1'b1, 14'h0013, 57'h55, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 9 || err !== 1'b0 || s_last_waddr !== 2'd2) begin errors++; $display("FAIL full_update: got cyc=%0d err=%b addr=%0d want 9/0/2", cyc, err, s_last_waddr); end
    checks++; if (s_mem[2] !== {14'h0013, 57'h55} || s_num !== 3'd4) begin errors++; $display("FAIL full_update_word: got %h num=%0d", s_mem[2], s_num); end
  endtask

  task automatic test_clear_priority();
    w0 = b_wcnt; z0 = b_zcnt; d0 = b_dcnt;
    run_cmd(1'b0, 1'b1, 1'b1, 14'h0044, 57'h4, 10, cyc, err, busy_seen);
    checks++; if (cyc !== 256 || err !== 1'b0) begin errors++; $display("FAIL prio_latency: got cyc=%0d err=%b want 256/0", cyc, err); end
    checks++; if (b_wcnt - w0 !== 256 || b_zcnt - z0 !== 256) begin errors++; $display("FAIL prio_writes: got all=%0d zero=%0d want 256/256", b_wcnt - w0, b_zcnt - z0); end
    checks++; if (b_dcnt - d0 !== 1) begin errors++; $display("FAIL prio_done_count: got %0d want 1", b_dcnt - d0); end
    checks++; if (b_num !== 9'd0 || b_mem[0] !== 71'd0) begin errors++; $display("FAIL prio_empty: got num=%0d mem0=%h want 0/0", b_num, b_mem[0]); end
    run_cmd(1'b0, 1'b0, 1'b1, 14'h0044, 57'h4, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 0 || b_last_waddr !== 8'd0 || b_num !== 9'd1) begin errors++; $display("FAIL prio_after_wr: got cyc=%0d addr=%0d num=%0d want 0/0/1", cyc, b_last_waddr, b_num); end
  endtask

  task automatic test_reset_mid_search();
    run_cmd(1'b0, 1'b0, 1'b1, 14'h0045, 57'h5, -1, cyc, err, busy_seen);
    run_cmd(1'b0, 1'b0, 1'b1, 14'h0046, 57'h6, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 6 || b_num !== 9'd3) begin errors++; $display("FAIL rst_setup: got cyc=%0d num=%0d want 6/3", cyc, b_num); end
    d0 = b_dcnt;
    @(negedge clk);
    flowid = 14'h003F; payload = 57'h7; b_wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_wr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (b_rd !== 1'b1 || b_raddr !== 8'd1 || b_busy !== 1'b1) begin errors++; $display("FAIL rst_at_index1: got rd=%b raddr=%0d busy=%b want 1/1/1", b_rd, b_raddr, b_busy); end
    rst = 1'b1;
    #1;
    checks++; if ({b_rd, b_wwr, b_busy, b_done, b_err} !== 5'b0 || b_raddr !== 8'd0 || b_num !== 9'd0) begin errors++; $display("FAIL rst_immediate: got %b raddr=%0d num=%0d want all 0", {b_rd, b_wwr, b_busy, b_done, b_err}, b_raddr, b_num); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (b_dcnt - d0 !== 0 || b_busy !== 1'b0) begin errors++; $display("FAIL rst_no_done: got done=%0d busy=%b want 0/0", b_dcnt - d0, b_busy); end
    run_cmd(1'b0, 1'b0, 1'b1, 14'h0047, 57'h8, -1, cyc, err, busy_seen);
    checks++; if (cyc !== 0 || b_last_waddr !== 8'd0 || b_num !== 9'd1) begin errors++; $display("FAIL rst_idle_after: got cyc=%0d addr=%0d num=%0d want 0/0/1", cyc, b_last_waddr, b_num); end
  endtask

  initial begin
    rst = 1'b1;
    b_wr = 1'b0; b_clear = 1'b0; s_wr = 1'b0; s_clear = 1'b0;
    flowid = '0; payload = '0;
    test_reset();
    test_clear();
    test_first_write();
    test_zero_reject();
    test_build();
    test_update();
    test_append();
    test_full();
    test_clear_priority();
    test_reset_mid_search();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
